// File: rtl/his_acq_scheduler_pkg.sv
// Shared types, default geometry and index-width helpers for the
// histogram acquisition scheduler.
package his_pkg;
  localparam int NP_DEF        = 10;
  localparam int PIXEL_NUM_DEF = 3;
  localparam int ACQ_NUM_DEF   = 2;
  localparam int DATA_NUM_DEF  = 2;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_CLEAR   = 3'd1,
    S_ACQ     = 3'd2,
    S_DRAIN   = 3'd3,
    S_READOUT = 3'd4,
    S_DONE    = 3'd5
  } t_sched_state;

  // Index width never drops below one bit so a count of 1 still has a register.
  function automatic int idx_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  function automatic int pw_width(input int pixel_num);
    return idx_w(pixel_num);
  endfunction

  function automatic int aw_width(input int acq_num);
    return idx_w(acq_num);
  endfunction
endpackage

// File: rtl/his_acq_scheduler_beat_counter.sv
// Nested data/pixel/acquisition counter; data index is the fastest digit.
module his_beat_counter
  import his_pkg::*;
#(
  parameter int PIXEL_NUM = PIXEL_NUM_DEF,
  parameter int ACQ_NUM   = ACQ_NUM_DEF,
  parameter int DATA_NUM  = DATA_NUM_DEF,
  parameter int PW        = pw_width(PIXEL_NUM),
  parameter int AW        = aw_width(ACQ_NUM)
) (
  input  logic          clk,
  input  logic          res,
  input  logic          clr_i,
  input  logic          inc_i,
  output logic [PW-1:0] p_o,
  output logic [AW-1:0] a_o,
  output logic          last_o
);
  localparam int DW = idx_w(DATA_NUM);

  logic [DW-1:0] d_q;
  logic [PW-1:0] p_q;
  logic [AW-1:0] a_q;
  logic          d_last, p_last, a_last;

  assign d_last = (d_q == DW'(DATA_NUM - 1));
  assign p_last = (p_q == PW'(PIXEL_NUM - 1));
  assign a_last = (a_q == AW'(ACQ_NUM - 1));

  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      d_q <= '0;
      p_q <= '0;
      a_q <= '0;
    end else if (clr_i) begin
      d_q <= '0;
      p_q <= '0;
      a_q <= '0;
    end else if (inc_i) begin
      d_q <= d_last ? '0 : d_q + 1'b1;
      if (d_last) begin
        p_q <= p_last ? '0 : p_q + 1'b1;
        if (p_last) a_q <= a_last ? '0 : a_q + 1'b1;
      end
    end
  end

  assign p_o    = p_q;
  assign a_o    = a_q;
  assign last_o = d_last & p_last & a_last;
endmodule

// File: rtl/his_acq_scheduler.sv
// Frame controller for the histogram builder: clear, tagged write stream,
// pipeline drain, then peak-vector readout over valid/ready.
module his_acq_scheduler
  import his_pkg::*;
#(
  parameter int NP         = NP_DEF,
  parameter int PIXEL_NUM  = PIXEL_NUM_DEF,
  parameter int ACQ_NUM    = ACQ_NUM_DEF,
  parameter int DATA_NUM   = DATA_NUM_DEF,
  parameter int CLR_CYCLES = 4,
  parameter int HB_LAT     = 3,
  parameter int PW         = pw_width(PIXEL_NUM),
  parameter int AW         = aw_width(ACQ_NUM)
) (
  input  logic                  clk,
  input  logic                  res,
  input  logic                  start,
  input  logic                  abort,
  input  logic                  ts_valid,
  input  logic [NP-1:0]         ts_data,
  output logic                  ts_ready,
  output logic                  hb_clear,
  output logic                  hb_wrEn,
  output logic [NP-1:0]         hb_data,
  output logic [PW-1:0]         hb_pixel,
  output logic [AW-1:0]         hb_acq,
  input  logic [NP*PIXEL_NUM-1:0] hb_peak,
  output logic                  pk_valid,
  input  logic                  pk_ready,
  output logic [PW-1:0]         pk_pixel,
  output logic [NP-1:0]         pk_data,
  output logic                  busy,
  output logic                  frame_done
);
  localparam int TMAX = (CLR_CYCLES > HB_LAT) ? CLR_CYCLES : HB_LAT;
  localparam int TW   = idx_w(TMAX);

  t_sched_state          state_q, state_d;
  logic [TW-1:0]         tmr_q, tmr_d;
  logic [PW-1:0]         rd_q, rd_d;
  logic [NP*PIXEL_NUM-1:0] cap_q;
  logic                  cap_en;
  logic                  wr_q;
  logic [NP-1:0]         data_q;
  logic [PW-1:0]         pix_q;
  logic [AW-1:0]         acq_q;
  logic                  accept, cnt_clr, bc_last;
  logic [PW-1:0]         bc_p;
  logic [AW-1:0]         bc_a;
  logic [NP-1:0]         pk_sel;

  // A beat presented alongside abort must not look accepted to the FIFO.
  assign ts_ready = (state_q == S_ACQ) & ~abort;
  assign accept   = ts_valid & ts_ready;
  assign cnt_clr  = abort | (state_q == S_IDLE);

  his_beat_counter #(
    .PIXEL_NUM(PIXEL_NUM), .ACQ_NUM(ACQ_NUM), .DATA_NUM(DATA_NUM), .PW(PW), .AW(AW)
  ) u_beat (
    .clk(clk), .res(res), .clr_i(cnt_clr), .inc_i(accept),
    .p_o(bc_p), .a_o(bc_a), .last_o(bc_last)
  );

  always_comb begin
    state_d = state_q;
    tmr_d   = tmr_q;
    rd_d    = rd_q;
    cap_en  = 1'b0;
    case (state_q)
      S_IDLE: if (start) begin
        state_d = S_CLEAR;
        tmr_d   = '0;
      end
      S_CLEAR: if (tmr_q == TW'(CLR_CYCLES - 1)) begin
        state_d = S_ACQ;
        tmr_d   = '0;
      end else tmr_d = tmr_q + 1'b1;
      S_ACQ: if (accept && bc_last) begin
        state_d = S_DRAIN;
        tmr_d   = '0;
      end
      S_DRAIN: if (tmr_q == TW'(HB_LAT - 1)) begin
        state_d = S_READOUT;
        tmr_d   = '0;
        rd_d    = '0;
        cap_en  = 1'b1;
      end else tmr_d = tmr_q + 1'b1;
      S_READOUT: if (pk_ready) begin
        if (rd_q == PW'(PIXEL_NUM - 1)) begin
          state_d = S_DONE;
          rd_d    = '0;
        end else rd_d = rd_q + 1'b1;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (abort) begin
      state_d = S_IDLE;
      tmr_d   = '0;
      rd_d    = '0;
      cap_en  = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      state_q <= S_IDLE;
      tmr_q   <= '0;
      rd_q    <= '0;
      cap_q   <= '0;
      wr_q    <= 1'b0;
      data_q  <= '0;
      pix_q   <= '0;
      acq_q   <= '0;
    end else begin
      state_q <= state_d;
      tmr_q   <= tmr_d;
      rd_q    <= rd_d;
      if (cap_en) cap_q <= hb_peak;
      if (abort) begin
        wr_q   <= 1'b0;
        data_q <= '0;
        pix_q  <= '0;
        acq_q  <= '0;
      end else begin
        wr_q <= accept;
        if (accept) begin
          data_q <= ts_data;
          pix_q  <= bc_p;
          acq_q  <= bc_a;
        end
      end
    end
  end

  always_comb begin
    pk_sel = '0;
    for (int p = 0; p < PIXEL_NUM; p++)
      if (rd_q == PW'(p)) pk_sel = cap_q[p*NP +: NP];
  end

  assign hb_clear   = (state_q == S_CLEAR);
  assign hb_wrEn    = wr_q;
  assign hb_data    = data_q;
  assign hb_pixel   = pix_q;
  assign hb_acq     = acq_q;
  assign pk_valid   = (state_q == S_READOUT);
  assign pk_pixel   = pk_valid ? rd_q : '0;
  assign pk_data    = pk_valid ? pk_sel : '0;
  assign busy       = (state_q != S_IDLE);
  assign frame_done = (state_q == S_DONE);
endmodule

// File: doc/his_acq_scheduler.md
Name: his_acq_scheduler

Overview:
- Frame-level controller in front of the histogram builder (hisBuilderFSM).
- On a start pulse it clears the builder bins, then accepts a stream of TDC timestamps. Each accepted timestamp is tagged with pixel and acquisition indices and forwarded as builder write strobes.
- After the builder pipeline drains, the block captures the per-pixel peak vector and serialises it over a valid/ready output port.
- Sits between the TDC front-end FIFO and hisBuilderFSM; it is the only driver of the builder's wrEn and data inputs.

Parameters:
- NP, 10, timestamp/peak width (matches `Np).
- PIXEL_NUM, 3, pixels per histogram RAM.
- ACQ_NUM, 2, acquisitions (laser shots) per frame.
- DATA_NUM, 2, timestamps per pixel per acquisition.
- CLR_CYCLES, 4, builder bin-clear duration in cycles.
- HB_LAT, 3, builder pipeline latency from last write to a valid peak vector.

Ports:
- clk  in  1  system clock
- res  in  1  reset, asynchronous, active-high
- start  in  1  frame start pulse; honoured in IDLE only
- abort  in  1  synchronous abort; overrides everything except res
- ts_valid  in  1  timestamp valid
- ts_data  in  NP  timestamp
- ts_ready  out  1  timestamp accepted when ts_valid&&ts_ready
- hb_clear  out  1  builder bin clear
- hb_wrEn  out  1  builder write strobe
- hb_data  out  NP  builder data
- hb_pixel  out  PW  pixel index, PW=$clog2(max(PIXEL_NUM,2))
- hb_acq  out  AW  acquisition index, AW=$clog2(max(ACQ_NUM,2))
- hb_peak  in  NP*PIXEL_NUM  builder peakResult, pixel p at [p*NP +: NP]
- pk_valid  out  1  peak output valid
- pk_ready  in  1  peak sink ready
- pk_pixel  out  PW  pixel index of pk_data
- pk_data  out  NP  peak bin
- busy  out  1  high whenever state != IDLE
- frame_done  out  1  one-cycle pulse after the last peak transfer

Behaviour:
- Reset (res=1, async): state=IDLE; all counters 0; every output 0 (ts_ready, hb_*, pk_*, busy, frame_done); peak capture register 0.
- States: IDLE, CLEAR, ACQ, DRAIN, READOUT, DONE.
- IDLE:
  - start=1 -> CLEAR; the clear counter loads 0.
- CLEAR:
  - hb_clear=1 for exactly CLR_CYCLES cycles, then -> ACQ.
- ACQ:
  - ts_ready=1 only in this state.
  - Beat order is acquisition-major, then pixel, then data: d increments first; on wrap (DATA_NUM-1 -> 0) p increments; on p wrap, a increments.
  - Each accepted beat produces hb_wrEn=1, hb_data=ts_data, hb_pixel=p, hb_acq=a, registered one cycle after acceptance. Indices are those of the accepted beat, pre-increment.
  - ts_valid=0: hb_wrEn=0 next cycle; counters hold; no timeout.
  - Acceptance of beat PIXEL_NUM*ACQ_NUM*DATA_NUM-1 -> DRAIN; ts_ready drops in that same transition cycle.
- DRAIN:
  - Waits HB_LAT cycles, counted from the cycle hb_wrEn of the last beat is high.
  - Then hb_peak is captured into a register and state -> READOUT with the pixel counter at 0.
- READOUT:
  - pk_valid=1; pk_pixel=counter; pk_data=captured[counter].
  - pk_data/pk_pixel stay stable while pk_valid&&!pk_ready.
  - On handshake the counter increments; after pixel PIXEL_NUM-1 -> DONE, with pk_valid low in the DONE cycle.
- DONE:
  - frame_done=1 for one cycle -> IDLE.
- busy=1 in every state except IDLE.
- abort=1 in any state: next cycle state=IDLE; counters cleared; hb_wrEn, hb_clear, pk_valid, ts_ready=0; no frame_done. A beat offered in the abort cycle is not accepted.
- start asserted outside IDLE is ignored.
- start and abort together in IDLE: abort wins, state stays IDLE.
- res mid-frame: immediate return to the reset values; the builder must then be cleared by the next frame's CLEAR.
- Counter wrap and comparisons use exact equality with N-1; no arithmetic overflow is possible because widths come from $clog2(max(N,2)).

Decomposition:
- Shared package his_pkg:
  - state enum t_sched_state.
  - Default NP, PIXEL_NUM, ACQ_NUM and DATA_NUM, mirroring parametersSiFH.vh.
  - Width functions for PW and AW.
- One natural sub-module, his_beat_counter: a nested d/p/a counter with inc, clr and last outputs.
- The FSM, drain timer and readout mux stay in the top.

Test Plan:
- Basic frame: start, ts_valid held high with values 0..11 -> hb_clear high 4 cycles; 12 hb_wrEn beats with (a,p,d) order (0,0,0),(0,0,1),(0,1,0)…(1,2,1); hb_data equals inputs; DRAIN 3 cycles; pk pixels 0,1,2 carry hb_peak={300,200,108}; frame_done single pulse; busy drops the next cycle.
- Stall: ts_valid toggles 1,0,0,1 -> only 2 hb_wrEn beats; indices advance only on accepted beats; total still 12 beats.
- Readout backpressure: pk_ready low 5 cycles on pixel 1 -> pk_data holds 200 and pk_pixel holds 1; no skip or duplicate.
- Abort at beat 6 -> IDLE next cycle; all outputs 0; no frame_done. A new start gives a clean CLEAR with indices from (0,0,0).
- Async res asserted mid-READOUT between clock edges -> outputs 0 before the next edge; start is ignored until res deasserts.
- start pulse during ACQ and start+abort in IDLE -> no effect; state and counters unchanged.
